// File: rtl/branch_resolve_queue_pkg.sv
// rtl/branch_resolve_queue_pkg.sv - shared types and constants for the branch resolve queue
package branch_resolve_queue_pkg;

   // Update sequencer states; encoding is fixed so it can be decoded by other blocks
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2
   } brq_state_t;

   // Predictor table index slice of a branch PC
   localparam int PC_IDX_HI = 11;
   localparam int PC_IDX_LO = 2;

   // One in-flight branch: where it is and which way it was predicted
   typedef struct packed {
      logic [31:0] pc;
      logic        pred;
   } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - fetch/execute/predictor signal bundle for the branch resolve queue
interface branch_resolve_queue_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
);
   logic                     PushValid;
   logic [31:0]              PushPC;
   logic                     PushPred;
   logic                     PushReady;
   logic                     ResValid;
   logic                     ResTaken;
   logic                     ResReady;
   logic                     Flush;
   logic                     UpdBranch;
   logic                     UpdTaken;
   logic [31:0]              UpdPC;
   logic                     Mispredict;
   logic                     Overflow;
   logic [$clog2(DEPTH):0]   Count;
   logic [CNT_W-1:0]         BranchCnt;
   logic [CNT_W-1:0]         MissCnt;

   // Environment side: fetch, execute and the predictor table
   modport master (
      output PushValid, PushPC, PushPred, ResValid, ResTaken, Flush,
      input  PushReady, ResReady, UpdBranch, UpdTaken, UpdPC,
             Mispredict, Overflow, Count, BranchCnt, MissCnt
   );

   // Queue side
   modport slave (
      input  PushValid, PushPC, PushPred, ResValid, ResTaken, Flush,
      output PushReady, ResReady, UpdBranch, UpdTaken, UpdPC,
             Mispredict, Overflow, Count, BranchCnt, MissCnt
   );
endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// rtl/branch_resolve_queue_fifo.sv - in-order entry storage with pointers and occupancy count
module brq_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          push,
   input  brq_entry_t    push_entry,
   input  logic          pop,
   output brq_entry_t    head,
   output logic [CW-1:0] count
);
   // Caller guarantees push only when not full, pop only when not empty,
   // and neither in a flush cycle.
   brq_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Entry storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_entry;
   end

   // Pointers wrap naturally at the power-of-two depth; count alone decides full/empty
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - queues predicted branches and sequences predictor updates on resolve
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic                    CLK,
   input  logic                    RESET,
   branch_resolve_queue_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   brq_state_t    state;
   brq_state_t    next_state;
   logic [CW-1:0] count;
   brq_entry_t    head;
   brq_entry_t    push_entry;
   logic          push_ready;
   logic          res_ready;
   logic          push_en;
   logic          pop_en;
   logic [31:0]   upd_pc;
   logic          upd_taken;
   logic          lat_pred;
   logic          upd_branch;
   logic          mispredict;
   logic          overflow;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] miss_cnt;

   // Readiness is judged on the pre-pop count, so a full queue never takes a push
   assign push_ready = (count != CW'(DEPTH));
   assign res_ready  = (state == IDLE) && (count != '0) && !bus.Flush;
   assign push_en    = bus.PushValid && push_ready && !bus.Flush;
   assign pop_en     = bus.ResValid && res_ready;
   assign push_entry = '{pc: bus.PushPC, pred: bus.PushPred};

   brq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (CLK),
      .resetn     (RESET),
      .flush      (bus.Flush),
      .push       (push_en),
      .push_entry (push_entry),
      .pop        (pop_en),
      .head       (head),
      .count      (count)
   );

   // Update sequencer state register; reset aborts any sequence in flight
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next state plus strobes decoded straight from state and latched outcome
   always_comb begin
      next_state = state;
      upd_branch = 1'b0;
      mispredict = 1'b0;
      case (state)
         IDLE:    if (pop_en) next_state = SETUP;
         SETUP: begin
            mispredict = (upd_taken != lat_pred);
            next_state = PULSE;
         end
         PULSE: begin
            upd_branch = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture the resolved branch so Upd* are stable through SETUP and PULSE
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         upd_pc    <= '0;
         upd_taken <= 1'b0;
         lat_pred  <= 1'b0;
      end else if (pop_en) begin
         upd_pc    <= head.pc;
         upd_taken <= bus.ResTaken;
         lat_pred  <= head.pred;
      end
   end

   // Sticky record of any push dropped because the queue was full
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         overflow <= 1'b0;
      else if (bus.PushValid && !push_ready)
         overflow <= 1'b1;
   end

   // Saturating statistics, counted once per update in SETUP
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         branch_cnt <= '0;
         miss_cnt   <= '0;
      end else if (state == SETUP) begin
         if (branch_cnt != '1)
            branch_cnt <= branch_cnt + CNT_ONE;
         if (mispredict && miss_cnt != '1)
            miss_cnt <= miss_cnt + CNT_ONE;
      end
   end

   assign bus.PushReady  = push_ready;
   assign bus.ResReady   = res_ready;
   assign bus.UpdBranch  = upd_branch;
   assign bus.UpdTaken   = upd_taken;
   assign bus.UpdPC      = upd_pc;
   assign bus.Mispredict = mispredict;
   assign bus.Overflow   = overflow;
   assign bus.Count      = count;
   assign bus.BranchCnt  = branch_cnt;
   assign bus.MissCnt    = miss_cnt;
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  8  in-flight branch entries; power of two, 2..64
  CNT_W  32  width of statistics counters
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset are listed first.
  CLK  in  1  clock; all state changes on rising edge
  RESET  in  1  reset, asynchronous, active-low
  PushValid  in  1  fetch has predicted a branch this cycle
  PushPC  in  32  PC of the predicted branch
  PushPred  in  1  predicted direction (1 = taken)
  PushReady  out  1  queue not full
  ResValid  in  1  execute resolves the oldest branch
  ResTaken  in  1  actual direction
  ResReady  out  1  resolution accepted this cycle
  Flush  in  1  discard all queued entries
  UpdBranch  out  1  predictor update strobe; a rising edge commits the update
  UpdTaken  out  1  outcome to train with
  UpdPC  out  32  PC to train
  Mispredict  out  1  one-cycle pulse on a wrong prediction
  Overflow  out  1  sticky flag: a push was dropped
  Count  out  $clog2(DEPTH)+1  occupied entries
  BranchCnt  out  CNT_W  resolved branches
  MissCnt  out  CNT_W  mispredicted branches

Function
REQ-003 The queue SHALL be an in-order FIFO of {PC, Pred} entries.
REQ-004 A push SHALL occur when PushValid && PushReady; PushReady = (Count != DEPTH).
REQ-005 A push while full SHALL be dropped and SHALL set Overflow, which holds until reset.
REQ-006 The update FSM SHALL have states IDLE, SETUP and PULSE.
REQ-007 ResReady SHALL be 1 only when state == IDLE and Count != 0.
REQ-008 ResValid with ResReady = 0 SHALL be ignored; there is no error flag.
REQ-009 On ResValid && ResReady the FSM SHALL pop the head, latch {head PC, ResTaken, head Pred}, and go IDLE -> SETUP.
REQ-010 In SETUP: UpdPC/UpdTaken are driven; UpdBranch = 0; Mispredict = (ResTaken != Pred) for this cycle only; next state is PULSE.
REQ-011 In PULSE: UpdBranch = 1; UpdPC/UpdTaken are unchanged; next state is IDLE.
REQ-012 In IDLE: UpdBranch = 0; UpdPC/UpdTaken hold their last values.
REQ-013 Resolve timing:
  - accepted resolves are at least 3 cycles apart
  - UpdPC/UpdTaken are stable one full cycle before and during the UpdBranch high cycle
  - UpdBranch is low for at least 2 cycles between pulses
REQ-014 A simultaneous push and pop SHALL both take effect; Count is unchanged; a push into a full queue in the same cycle as a pop SHALL NOT occur, because PushReady is evaluated before the pop.
REQ-015 Flush SHALL clear Count and the pointers in the next cycle.
  - an in-progress SETUP/PULSE sequence still completes
  - a push in the Flush cycle is discarded
  - a resolve in the Flush cycle is not accepted (ResReady forced to 0)
REQ-016 BranchCnt SHALL increment in SETUP; MissCnt SHALL increment in SETUP when Mispredict = 1; both saturate at all-ones.
REQ-017 Pointers SHALL wrap modulo DEPTH; Count SHALL be the only full/empty source.
REQ-018 All outputs SHALL be registered or decoded directly from state; no combinational path from ResValid to Upd* outputs.

Reset
REQ-019 While RESET = 0 the block SHALL hold, asynchronously:
  - Count = 0, pointers = 0, state = IDLE
  - UpdBranch = 0, UpdTaken = 0, UpdPC = 0
  - Mispredict = 0, Overflow = 0, BranchCnt = 0, MissCnt = 0
REQ-020 Reset mid-sequence (SETUP/PULSE) SHALL abort the update; no UpdBranch pulse is issued after release.
REQ-021 Entry storage SHALL need no reset; it SHALL be unobservable while Count = 0.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (IDLE = 0, SETUP = 1, PULSE = 2) and the PC index slice constants (bits 11:2).
REQ-023 One sub-module, brq_fifo (storage, pointers, Count), SHALL be instantiated; the FSM and counters stay in the top level.
REQ-024 UpdBranch/UpdTaken/UpdPC SHALL connect directly to the predictor table's isBranch/isTaken/InstrPC.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (stimulus -> required response):
  - Push PC 0x00000040 Pred = 1, then resolve Taken = 1 -> SETUP cycle UpdPC = 0x40, UpdTaken = 1, Mispredict = 0; next cycle UpdBranch = 1; BranchCnt = 1, MissCnt = 0.
  - Push Pred = 0, resolve Taken = 1 -> Mispredict pulses for exactly 1 cycle; MissCnt = 1.
  - 9 pushes, DEPTH = 8 -> PushReady = 0 after the 8th push, Overflow = 1, Count = 8; then 8 resolves -> 8 UpdBranch pulses with PCs in push order; Count = 0.
  - ResValid held high with 3 entries queued -> accepts exactly every 3rd cycle; UpdBranch high/low pattern 0,1,0 repeating.
  - Flush with 5 entries during PULSE -> pulse completes; Count = 0 next cycle; ResReady = 0 afterwards.
  - RESET asserted in SETUP -> all outputs 0 immediately; no UpdBranch pulse after release.
